// File: rtl/spi_controller.sv
// SPI mode-0 frame controller: one 16-bit frame {rw, addr[6:0], data[7:0]}
// per start request, MSB first, driving sclk/ncs/sdi from the system clock.
// Optional macro SPI_READBACK_EN adds the sdo input and rdata output, and
// captures the peripheral's data byte on read (rw=0) frames.
module spi_controller #(
    parameter int CLK_DIV = 4,   // clk cycles per sclk half-period (>=2)
    parameter int CS_HOLD = 2,   // extra ncs-low cycles after last falling edge
    parameter int CS_GAP  = 4    // ncs-high cycles before done / next frame (>=4)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       ncs,
    output logic       sdi
`ifdef SPI_READBACK_EN
    ,
    input  logic       sdo,
    output logic [7:0] rdata
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    // Terminal counts for the shared cycle counter. HOLD_LAST is unused when
    // CS_HOLD is 0 because the HOLD state is then never entered.
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(CS_HOLD - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);

    state_t      r_state;
    logic [15:0] r_cnt;       // cycles spent in the current half-period/state
    logic [4:0]  r_bit_cnt;   // number of rising sclk edges issued (1..16)
    logic [15:0] r_shift;     // bit 15 is the sdi line; cleared outside a frame
    logic        r_busy;
    logic        r_done;
    logic        r_sclk;
    logic        r_ncs;
`ifdef SPI_READBACK_EN
    logic        r_rw;
    logic [7:0]  r_rx;
    logic [7:0]  r_rdata;
`endif

    // Frame sequencer: all outputs are registered state of this block
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_bit_cnt <= 5'd0;
            r_shift   <= 16'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_ncs     <= 1'b1;
`ifdef SPI_READBACK_EN
            r_rw      <= 1'b0;
            r_rx      <= 8'd0;
            r_rdata   <= 8'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift   <= {rw, addr, wdata};
                        r_ncs     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_cnt     <= 16'd0;
                        r_bit_cnt <= 5'd0;
                        r_state   <= S_SETUP;
`ifdef SPI_READBACK_EN
                        r_rw      <= rw;
`endif
                    end
                end
                S_SETUP: begin
                    if (r_cnt == DIV_LAST) begin
                        r_cnt     <= 16'd0;
                        r_sclk    <= 1'b1;
                        r_bit_cnt <= 5'd1;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != DIV_LAST) begin
                        r_cnt <= r_cnt + 16'd1;
                    end else begin
                        r_cnt <= 16'd0;
                        if (r_sclk) begin
                            // Falling edge: advance sdi except after bit 16,
                            // so frame[0] stays on the line through HOLD.
                            r_sclk <= 1'b0;
                            if (r_bit_cnt != 5'd16)
                                r_shift <= {r_shift[14:0], 1'b0};
`ifdef SPI_READBACK_EN
                            // Data phase is bits 7..0, i.e. rising edges 9..16
                            if (r_bit_cnt >= 5'd9)
                                r_rx <= {r_rx[6:0], sdo};
`endif
                        end else if (r_bit_cnt != 5'd16) begin
                            r_sclk    <= 1'b1;
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end else if (CS_HOLD == 0) begin
                            r_ncs   <= 1'b1;
                            r_shift <= 16'd0;
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt   <= 16'd0;
                        r_ncs   <= 1'b1;
                        r_shift <= 16'd0;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= 16'd0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
`ifdef SPI_READBACK_EN
                        if (!r_rw)
                            r_rdata <= r_rx;
`endif
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sclk = r_sclk;
    assign ncs  = r_ncs;
    assign sdi  = r_shift[15];
`ifdef SPI_READBACK_EN
    assign rdata = r_rdata;
`endif

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI mode-0 controller that initiates one 16-bit frame per request toward the on-chip SPI peripheral register file. Frame format, MSB first: R/W bit (1 = write), 7-bit address, 8-bit data. It drives sclk, ncs and sdi from the system clock. It sits in the test/bring-up path, for example a config sequencer, and drives the peripheral's sclk/ncs/sdi pins.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period; legal range ≥2, so the peripheral's 2-FF synchroniser resolves every edge
CS_HOLD, 2, extra clk cycles ncs stays low after the last sclk falling edge; legal range ≥0
CS_GAP, 4, clk cycles ncs stays high after frame end before done/next frame; legal range ≥4, covering the peripheral's sync plus commit latency

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  request pulse; sampled only in IDLE
rw  input  1  frame R/W bit; captured with start
addr  input  7  frame address; captured with start
wdata  input  8  frame data; captured with start
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse at frame completion
sclk  output  1  serial clock; idles low
ncs  output  1  chip select, active-low
sdi  output  1  serial data to peripheral
sdo  input  1  serial data from peripheral (SPI_READBACK_EN only)
rdata  output  8  captured read data (SPI_READBACK_EN only)

Behaviour:
- One clock domain (clk); reset is synchronous, active-high (rst). All outputs are registered.
- Reset values: busy=0, done=0, sclk=0, ncs=1, sdi=0, rdata=0x00. FSM returns to IDLE.
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE:
  - On start=1, latch frame = {rw, addr, wdata} into a 16-bit shift register.
  - Next cycle: ncs=0, sdi=frame[15], busy=1; enter SETUP.
- SETUP: sclk low for CLK_DIV cycles.
- SHIFT: 16 bits. Each bit is CLK_DIV cycles sclk=1, then CLK_DIV cycles sclk=0.
  - On each falling edge except the 16th, sdi moves to the next bit in the same cycle sclk goes low.
  - sdi is therefore stable ≥CLK_DIV cycles before every rising edge.
  - A 5-bit counter tracks bits. Exactly 16 rising edges per frame.
- HOLD:
  - After the 16th low half-period, ncs stays low CS_HOLD further cycles.
  - sdi holds frame[0].
  - Skipped when CS_HOLD=0.
- GAP: ncs=1, sdi=0, sclk=0 for CS_GAP cycles.
- Completion:
  - The cycle after GAP ends: done=1 for exactly one cycle and busy=0 in the same cycle; state is IDLE.
  - start on that cycle is accepted.
- ncs low duration per frame = CLK_DIV*33 + CS_HOLD cycles (134 at defaults).
- Start-to-done latency = 1 + CLK_DIV*33 + CS_HOLD + CS_GAP cycles (139 at defaults).
- start while busy=1: ignored, not queued. Input changes mid-frame have no effect.
- rw=0 frames are shifted identically; only bit 15 differs.
- Reset mid-frame: next edge forces the reset values. No done pulse. The partial frame is abandoned; the peripheral discards it because bit_count≠16.

Optional Feature:
SPI_READBACK_EN
- Defined:
  - sdo and rdata ports exist.
  - During bits 7..0 (data phase), sdo is sampled on the last clk cycle of each sclk-high half-period and shifted MSB first into an internal register.
  - rdata is updated from that register only on rw=0 frames, in the cycle done pulses. It holds its value otherwise.
- Undefined: no sdo/rdata ports and no capture logic; behaviour otherwise identical.

Test Plan:
- Defaults, rw=1, addr=0x04, wdata=0x80 → sdi bits at the 16 rising edges = 0x8480; ncs low 134 cycles; done 139 cycles after start. A connected spi_peripheral reaches pwm_duty_cycle=0x80.
- Back-to-back writes addr 0x00/0xA5 then 0x01/0x5A (second start on the done cycle) → en_reg_out_7_0=0xA5, en_reg_out_15_8=0x5A; ncs high ≥CS_GAP between frames.
- rw=0, addr=0x02, wdata=0xFF → first sdi bit 0. Peripheral registers unchanged. With SPI_READBACK_EN and sdo driven with 0x3C: rdata=0x3C at done.
- start pulsed at cycles 10, 40, 90 of an active frame → ignored; exactly one done pulse; sdi pattern unchanged.
- rst=1 at the 8th rising sclk edge → next cycle ncs=1, sclk=0, busy=0; no done pulse. Peripheral outputs unchanged.
- CLK_DIV=2, CS_HOLD=0 → sclk high/low 2 cycles each; ncs low 66 cycles; frame correctly received by the peripheral.
